cpu_ctrl_seq: RTL

Microcoded control sequencer for the 8-bit CPU datapath. It steps fetch/decode/execute T-states and drives the load enables of the datapath's enable-gated common registers (PC, MAR, IR, A, B, OUT, flags), the bus source select, the ALU mode and the RAM write strobe. It sits between the IR opcode field and every datapath register, and is the only source of their enable inputs.

---
 rtl/cpu_ctrl_pkg.sv | 55 +++++
 rtl/cpu_ctrl_decode.sv | 96 +++++++++
 rtl/cpu_ctrl_seq.sv | 75 +++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU control sequencer.
// States, opcodes, bus sources and the control word bundle.
package cpu_ctrl_pkg;

    localparam int OPC_W = 4;
    localparam int BUS_W = 3;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd5
    } state_t;

    typedef enum logic [OPC_W-1:0] {
        NOP = 4'h0,
        LDA = 4'h1,
        ADD = 4'h2,
        SUB = 4'h3,
        STA = 4'h4,
        LDI = 4'h5,
        JMP = 4'h6,
        JC  = 4'h7,
        JZ  = 4'h8,
        OUT = 4'hE,
        HLT = 4'hF
    } opcode_t;

    typedef enum logic [BUS_W-1:0] {
        NONE = 3'd0,
        PC   = 3'd1,
        RAM  = 3'd2,
        IR   = 3'd3,
        A    = 3'd4,
        ALU  = 3'd5
    } bus_sel_t;

    typedef struct packed {
        logic     pc_inc;
        logic     pc_load;
        logic     mar_en;
        logic     ir_en;
        logic     a_en;
        logic     b_en;
        logic     out_en;
        logic     flag_en;
        logic     ram_we;
        logic     sub;
        logic     halt;
        bus_sel_t bus;
    } ctrl_word_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Microcode decode: (state, opcode, flags) -> control word + next state.
// Purely combinational; state register and gating live in the top.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t           state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             carry,
    input  logic             zero,
    output ctrl_word_t       cw,
    output state_t           nxt
);

    opcode_t opc;
    assign opc = opcode_t'(opcode);

    // Micro-step table: one control word per T-state, fetch then execute
    always_comb begin
        cw  = '0;
        nxt = T0;
        unique case (state)
            T0: begin
                cw.bus    = PC;
                cw.mar_en = 1'b1;
                nxt       = T1;
            end
            T1: begin
                cw.bus    = RAM;
                cw.ir_en  = 1'b1;
                cw.pc_inc = 1'b1;
                nxt       = T2;
            end
            T2: begin
                case (opc)
                    LDA, ADD, SUB, STA: begin
                        cw.bus    = IR;
                        cw.mar_en = 1'b1;
                        nxt       = T3;
                    end
                    LDI: begin
                        cw.bus  = IR;
                        cw.a_en = 1'b1;
                    end
                    JMP: begin
                        cw.bus     = IR;
                        cw.pc_load = 1'b1;
                    end
                    JC: begin
                        cw.bus     = IR;
                        cw.pc_load = carry;
                    end
                    JZ: begin
                        cw.bus     = IR;
                        cw.pc_load = zero;
                    end
                    OUT: begin
                        cw.bus    = A;
                        cw.out_en = 1'b1;
                    end
                    HLT:     nxt = HALT;
                    default: nxt = T0;
                endcase
            end
            T3: begin
                case (opc)
                    LDA: begin
                        cw.bus  = RAM;
                        cw.a_en = 1'b1;
                    end
                    ADD, SUB: begin
                        cw.bus  = RAM;
                        cw.b_en = 1'b1;
                        nxt     = T4;
                    end
                    STA: begin
                        cw.bus    = A;
                        cw.ram_we = 1'b1;
                    end
                    default: nxt = T0;
                endcase
            end
            T4: begin
                cw.bus     = ALU;
                cw.a_en    = 1'b1;
                cw.flag_en = 1'b1;
                cw.sub     = (opc == SUB);
            end
            HALT: begin
                cw.halt = 1'b1;
                nxt     = HALT;
            end
            default: nxt = T0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer top: T-state register, step gating, reset masking.
// Sole source of every datapath register enable.
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int pOPC_WIDTH     = 4,
    parameter int pBUS_SEL_WIDTH = 3
) (
    input  logic                      iclk,
    input  logic                      irst_n,
    input  logic                      istep,
    input  logic [pOPC_WIDTH-1:0]     iopcode,
    input  logic                      icarry,
    input  logic                      izero,
    output logic                      opc_inc,
    output logic                      opc_load,
    output logic                      omar_en,
    output logic                      oir_en,
    output logic                      oa_en,
    output logic                      ob_en,
    output logic                      oout_en,
    output logic                      oflag_en,
    output logic                      oram_we,
    output logic                      osub,
    output logic [pBUS_SEL_WIDTH-1:0] obus_sel,
    output logic                      ohalt,
    output logic [2:0]                ostate
);

    state_t     state;
    state_t     nxt;
    ctrl_word_t cw;
    ctrl_word_t cw_g;

    cpu_ctrl_decode u_decode (
        .state  (state),
        .opcode (iopcode),
        .carry  (icarry),
        .zero   (izero),
        .cw     (cw),
        .nxt    (nxt)
    );

    // State advances only on a stepped clock; reset returns to T0 at once
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state <= T0;
        end else if (istep) begin
            state <= nxt;
        end
    end

    // Freeze or reset drops every output so no partial write can occur
    always_comb begin
        cw_g = cw;
        if (!(istep && irst_n)) begin
            cw_g = '0;
        end
    end

    assign opc_inc  = cw_g.pc_inc;
    assign opc_load = cw_g.pc_load;
    assign omar_en  = cw_g.mar_en;
    assign oir_en   = cw_g.ir_en;
    assign oa_en    = cw_g.a_en;
    assign ob_en    = cw_g.b_en;
    assign oout_en  = cw_g.out_en;
    assign oflag_en = cw_g.flag_en;
    assign oram_we  = cw_g.ram_we;
    assign osub     = cw_g.sub;
    assign obus_sel = cw_g.bus;
    assign ohalt    = cw_g.halt;
    assign ostate   = state;

endmodule
